// File: rtl/grid_feeder_if.sv
// rtl/grid_feeder_if.sv - control, memory-read and lane-output signals of the grid feeder
interface grid_feeder_if #(
    parameter int NUM_SIZE   = 16,
    parameter int GRID_SIZE  = 2,
    parameter int ADDR_WIDTH = 5
);
    logic                          start;
    logic [ADDR_WIDTH-1:0]         base_addr;
    logic [ADDR_WIDTH-1:0]         num_rows;
    logic                          mem_rd_en;
    logic [ADDR_WIDTH-1:0]         mem_addr;
    logic [NUM_SIZE-1:0]           mem_rd_data;
    logic [GRID_SIZE*NUM_SIZE-1:0] grid_data;
    logic [GRID_SIZE-1:0]          grid_valid;
    logic                          busy;
    logic                          done;

    modport master (
        output start, base_addr, num_rows, mem_rd_data,
        input  mem_rd_en, mem_addr, grid_data, grid_valid, busy, done
    );

    modport slave (
        input  start, base_addr, num_rows, mem_rd_data,
        output mem_rd_en, mem_addr, grid_data, grid_valid, busy, done
    );
endinterface

// File: rtl/grid_feeder.sv
// rtl/grid_feeder.sv - tile fetch buffer with diagonally skewed lane feed for a systolic grid
module grid_feeder #(
    parameter int NUM_SIZE   = 16,
    parameter int GRID_SIZE  = 2,
    parameter int ADDR_WIDTH = 5,
    parameter int MAX_ROWS   = 8
) (
    input  logic         clk,
    input  logic         rst,
    grid_feeder_if.slave bus
);
    localparam int TILE_N = MAX_ROWS * GRID_SIZE;
    localparam int IDX_W  = (TILE_N > 1) ? $clog2(TILE_N) : 1;
    localparam int CNT_W  = $clog2(TILE_N + GRID_SIZE + 1);
    localparam int KC_W   = $clog2(MAX_ROWS + 1);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_FEED, S_DONE} state_t;

    state_t                        state_q, state_d;
    logic [ADDR_WIDTH-1:0]         base_q;
    logic [KC_W-1:0]               kc_q, kc_start;
    logic [CNT_W-1:0]              rd_idx, cap_idx, feed_t, n_words, feed_len;
    logic                          cap_valid;
    logic [NUM_SIZE-1:0]           tile [TILE_N];
    logic [GRID_SIZE*NUM_SIZE-1:0] lane_data;
    logic [GRID_SIZE-1:0]          lane_valid;

    assign kc_start = (bus.num_rows > ADDR_WIDTH'(MAX_ROWS)) ? KC_W'(MAX_ROWS) : KC_W'(bus.num_rows);
    assign n_words  = CNT_W'(kc_q) * CNT_W'(GRID_SIZE);
    assign feed_len = CNT_W'(kc_q) + CNT_W'(GRID_SIZE - 1);
    assign bus.busy = (state_q != S_IDLE);
    assign bus.done = (state_q == S_DONE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = (kc_start == '0) ? S_DONE : S_FETCH;
            S_FETCH: if (cap_valid && (cap_idx == n_words - CNT_W'(1))) state_d = S_FEED;
            S_FEED:  if (feed_t == feed_len) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // Lane i at feed step t carries tile row t-i, producing the diagonal skew.
    always_comb begin
        int r;
        r          = 0;
        lane_data  = '0;
        lane_valid = '0;
        for (int i = 0; i < GRID_SIZE; i++) begin
            r = int'(feed_t) - i;
            if (r >= 0 && r < int'(kc_q)) begin
                lane_valid[i]                     = 1'b1;
                lane_data[i*NUM_SIZE +: NUM_SIZE] = tile[IDX_W'(r * GRID_SIZE + i)];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            base_q         <= '0;
            kc_q           <= '0;
            rd_idx         <= '0;
            cap_idx        <= '0;
            feed_t         <= '0;
            cap_valid      <= 1'b0;
            bus.mem_rd_en  <= 1'b0;
            bus.mem_addr   <= '0;
            bus.grid_data  <= '0;
            bus.grid_valid <= '0;
        end else begin
            state_q       <= state_d;
            cap_valid     <= 1'b0;
            bus.mem_rd_en <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    rd_idx  <= '0;
                    cap_idx <= '0;
                    if (bus.start) begin
                        base_q <= bus.base_addr;
                        kc_q   <= kc_start;
                    end
                    if (state_d == S_FETCH) begin
                        bus.mem_rd_en <= 1'b1;
                        bus.mem_addr  <= bus.base_addr;
                        rd_idx        <= CNT_W'(1);
                    end
                end
                S_FETCH: begin
                    // Read data returns one cycle after the strobe, so capture trails issue by one.
                    cap_valid <= bus.mem_rd_en;
                    if (cap_valid) cap_idx <= cap_idx + CNT_W'(1);
                    if (rd_idx < n_words) begin
                        bus.mem_rd_en <= 1'b1;
                        bus.mem_addr  <= base_q + ADDR_WIDTH'(rd_idx);
                        rd_idx        <= rd_idx + CNT_W'(1);
                    end
                end
                default: ;
            endcase
            if (state_d == S_FEED) begin
                bus.grid_data  <= lane_data;
                bus.grid_valid <= lane_valid;
                feed_t         <= feed_t + CNT_W'(1);
            end else begin
                bus.grid_data  <= '0;
                bus.grid_valid <= '0;
                feed_t         <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (cap_valid) tile[IDX_W'(cap_idx)] <= bus.mem_rd_data;
    end
endmodule

// File: tb/tb_grid_feeder.sv
// tb/tb_grid_feeder.sv - table-driven and randomized checks of grid_feeder against a cycle-level model
module tb_grid_feeder;
    localparam int W     = 16;
    localparam int G     = 2;
    localparam int AW    = 5;
    localparam int DEPTH = 32;
    localparam int MAXR  = 8;

    typedef struct {
        int base;
        int rows;
        bit restart;
        int exp_reads;
        int exp_done;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    grid_feeder_if #(.NUM_SIZE(W), .GRID_SIZE(G), .ADDR_WIDTH(AW)) bus();

    grid_feeder #(.NUM_SIZE(W), .GRID_SIZE(G), .ADDR_WIDTH(AW), .MAX_ROWS(MAXR)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [W-1:0] mem [DEPTH];
    always @(posedge clk) if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_addr];

    int vectors     = 0;
    int miscompares = 0;

    logic [G*W-1:0] s_data  [64];
    logic [G-1:0]   s_valid [64];
    logic [AW-1:0]  s_addr  [64];
    logic           s_done  [64];
    logic           s_busy  [64];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Expected per-cycle behaviour derived directly from the memory contents and tile geometry.
    task automatic run(input int base, input int rows, input bit restart,
                       output int nreads, output int done_cyc);
        int kc, n, dc, t, r;
        logic [G*W-1:0] ed;
        logic [G-1:0]   ev;
        logic           erd;
        logic [AW-1:0]  eaddr;
        kc       = (rows > MAXR) ? MAXR : rows;
        n        = kc * G;
        dc       = (kc == 0) ? 1 : n + kc + G + 1;
        nreads   = 0;
        done_cyc = -1;
        @(negedge clk);
        bus.start     = 1'b1;
        bus.base_addr = AW'(base);
        bus.num_rows  = AW'(rows);
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int c = 1; c <= dc + 2; c++) begin
            @(negedge clk);
            erd   = (c <= n);
            eaddr = AW'((base + c - 1) % DEPTH);
            ev    = '0;
            ed    = '0;
            t     = c - n - 2;
            for (int i = 0; i < G; i++) begin
                r = t - i;
                if (kc > 0 && r >= 0 && r < kc) begin
                    ev[i]       = 1'b1;
                    ed[i*W +: W] = mem[(base + r * G + i) % DEPTH];
                end
            end
            s_data[c]  = bus.grid_data;
            s_valid[c] = bus.grid_valid;
            s_addr[c]  = bus.mem_addr;
            s_done[c]  = bus.done;
            s_busy[c]  = bus.busy;
            if (bus.mem_rd_en) nreads++;
            if (bus.done && done_cyc < 0) done_cyc = c;
            chk("mem_rd_en", 64'(bus.mem_rd_en), 64'(erd));
            if (erd) chk("mem_addr", 64'(bus.mem_addr), 64'(eaddr));
            chk("grid_valid", 64'(bus.grid_valid), 64'(ev));
            chk("grid_data", 64'(bus.grid_data), 64'(ed));
            chk("busy", 64'(bus.busy), 64'(c <= dc));
            chk("done", 64'(bus.done), 64'(c == dc));
            bus.start = restart && (c == 2 || c == n + 3 || c == dc);
            if (bus.start) begin
                bus.base_addr = AW'(17);
                bus.num_rows  = AW'(5);
            end
        end
        bus.start = 1'b0;
    endtask

    initial begin
        vec_t vt [8];
        int   nr, dcyc, rb, rr, kc;
        logic [W-1:0] basic [8];

        vt[0] = '{0,  2,  1'b0, 4,  9};
        vt[1] = '{4,  2,  1'b0, 4,  9};
        vt[2] = '{30, 2,  1'b0, 4,  9};
        vt[3] = '{0,  0,  1'b0, 0,  1};
        vt[4] = '{0,  12, 1'b0, 16, 27};
        vt[5] = '{0,  2,  1'b1, 4,  9};
        vt[6] = '{7,  1,  1'b0, 2,  6};
        vt[7] = '{31, 8,  1'b0, 16, 27};

        basic[0] = 16'd3;     basic[1] = 16'hFFFF; basic[2] = 16'hFFFC; basic[3] = 16'd1;
        basic[4] = 16'd2;     basic[5] = 16'd1;    basic[6] = 16'd7;    basic[7] = 16'd8;
        for (int k = 0; k < DEPTH; k++) mem[k] = W'($urandom);
        for (int k = 0; k < 8; k++) mem[k] = basic[k];

        bus.start = 1'b0; bus.base_addr = '0; bus.num_rows = '0; bus.mem_rd_data = '0;
        #12;
        chk("reset_outputs", 64'({bus.mem_rd_en, bus.mem_addr, bus.grid_valid, bus.busy, bus.done}), 64'(0));
        chk("reset_grid_data", 64'(bus.grid_data), 64'(0));
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 8; k++) begin
            run(vt[k].base, vt[k].rows, vt[k].restart, nr, dcyc);
            chk("read_count", 64'(nr), 64'(vt[k].exp_reads));
            chk("done_cycle", 64'(dcyc), 64'(vt[k].exp_done));
            if (k == 0 || k == 5) begin
                chk("basic_c6_data", 64'(s_data[6]), 64'h0000_0003);
                chk("basic_c6_valid", 64'(s_valid[6]), 64'h1);
                chk("basic_c7_data", 64'(s_data[7]), 64'hFFFF_FFFC);
                chk("basic_c7_valid", 64'(s_valid[7]), 64'h3);
                chk("basic_c8_data", 64'(s_data[8]), 64'h0001_0000);
                chk("basic_c8_valid", 64'(s_valid[8]), 64'h2);
                chk("basic_c9_done", 64'(s_done[9]), 64'h1);
                chk("basic_c10_busy", 64'(s_busy[10]), 64'h0);
            end
            if (k == 1) begin
                chk("offset_c6_data", 64'(s_data[6]), 64'h0000_0002);
                chk("offset_c7_data", 64'(s_data[7]), 64'h0001_0007);
                chk("offset_c8_data", 64'(s_data[8]), 64'h0008_0000);
            end
            if (k == 2) begin
                chk("wrap_addr1", 64'(s_addr[1]), 64'd30);
                chk("wrap_addr2", 64'(s_addr[2]), 64'd31);
                chk("wrap_addr3", 64'(s_addr[3]), 64'd0);
                chk("wrap_addr4", 64'(s_addr[4]), 64'd1);
                chk("wrap_c7_data", 64'(s_data[7]), 64'({mem[31], mem[0]}));
            end
        end

        // Reset in the middle of FEED abandons the transfer.
        @(negedge clk);
        bus.start = 1'b1; bus.base_addr = '0; bus.num_rows = AW'(2);
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (7) @(negedge clk);
        chk("pre_rst_valid", 64'(bus.grid_valid), 64'h3);
        rst = 1'b1;
        #1;
        chk("rst_async_ctrl", 64'({bus.mem_rd_en, bus.grid_valid, bus.busy, bus.done}), 64'(0));
        chk("rst_async_data", 64'(bus.grid_data), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk("post_rst_idle", 64'({bus.mem_rd_en, bus.grid_valid, bus.busy, bus.done}), 64'(0));
        end
        run(0, 2, 1'b0, nr, dcyc);
        chk("rerun_reads", 64'(nr), 64'd4);
        chk("rerun_done", 64'(dcyc), 64'd9);
        chk("rerun_c7_data", 64'(s_data[7]), 64'hFFFF_FFFC);

        for (int k = 0; k < 20; k++) begin
            for (int m = 0; m < DEPTH; m++) mem[m] = W'($urandom);
            rb = int'($urandom_range(0, DEPTH - 1));
            rr = int'($urandom_range(0, DEPTH - 1));
            kc = (rr > MAXR) ? MAXR : rr;
            run(rb, rr, 1'b0, nr, dcyc);
            chk("rand_reads", 64'(nr), 64'(kc * G));
            chk("rand_done", 64'(dcyc), 64'((kc == 0) ? 1 : kc * G + kc + G + 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
